// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, hazard/branch controls and IF/ID outputs.
// The master side is the fetch stage; the slave side is the surrounding core.
interface fetch_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic [PC_WIDTH-1:0] PC_ID;
    logic [0:31]         Instr_ID;
    logic                Valid_ID;
    logic [0:4]          OpCode;
    logic [0:4]          InstructionP1;
    logic [0:9]          InstructionP2;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, PC_ID, Instr_ID, Valid_ID, OpCode, InstructionP1, InstructionP2
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, PC_ID, Instr_ID, Valid_ID, OpCode, InstructionP1, InstructionP2
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register for the SIMD AES core.
// Synchronous imem (one-cycle read); a one-entry skid buffer keeps the in-flight word across stalls.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int unsigned INSTR_WIDTH = 32;

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    fetch_addr;
    logic                   fetch_pending;
    logic [0:INSTR_WIDTH-1] hold_instr;
    logic                   hold_valid;
    logic [PC_WIDTH-1:0]    pc_id;
    logic [0:INSTR_WIDTH-1] instr_id;
    logic                   valid_id;

    logic                   load_valid;
    logic [0:INSTR_WIDTH-1] load_word;

    // A word is available for ID either from the skid buffer or straight off the memory port.
    assign load_valid = fetch_pending | hold_valid;
    assign load_word  = hold_valid ? hold_instr : INSTR_WIDTH'(bus.imem_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            fetch_addr    <= '0;
            fetch_pending <= 1'b0;
            hold_instr    <= '0;
            hold_valid    <= 1'b0;
            pc_id         <= '0;
            instr_id      <= '0;
            valid_id      <= 1'b0;
        end else if (bus.branch_taken) begin
            pc            <= bus.branch_target;
            fetch_pending <= 1'b0;
            hold_valid    <= 1'b0;
            instr_id      <= '0;
            valid_id      <= 1'b0;
        end else if (bus.stall) begin
            // Park the in-flight word once; later stall cycles just hold.
            if (fetch_pending && !hold_valid) begin
                hold_instr    <= INSTR_WIDTH'(bus.imem_rdata);
                hold_valid    <= 1'b1;
                fetch_pending <= 1'b0;
            end
        end else begin
            pc            <= pc + PC_WIDTH'(PC_STEP);
            fetch_addr    <= pc;
            fetch_pending <= 1'b1;
            hold_valid    <= 1'b0;
            pc_id         <= fetch_addr;
            valid_id      <= load_valid;
            instr_id      <= load_valid ? load_word : '0;
        end
    end

    assign bus.imem_addr     = pc;
    assign bus.PC_ID         = pc_id;
    assign bus.Instr_ID      = instr_id;
    assign bus.Valid_ID      = valid_id;
    assign bus.OpCode        = instr_id[0:4];
    assign bus.InstructionP1 = instr_id[27:31];
    assign bus.InstructionP2 = instr_id[22:31];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a synchronous ROM model with ROM[n] = n + 0x100
// and one special word at index 0x20; expected values are hand-computed per scenario.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] rom [0:255];

    fetch_if #(.PC_WIDTH(32)) bus ();

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset and run until PC_ID equals the requested word index (0 -> PC_ID=0).
    task automatic restart(input int words);
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i <= words; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b0 || bus.PC_ID !== 32'h0 || bus.Instr_ID !== 32'h0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b pc_id=%h instr=%h addr=%h, required 0/0/0/0",
                     bus.Valid_ID, bus.PC_ID, bus.Instr_ID, bus.imem_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b0 || bus.Instr_ID !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_bubble: valid=%b instr=%h, required 0/0", bus.Valid_ID, bus.Instr_ID);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'(4 * i) || bus.Instr_ID !== 32'(32'h100 + i)) begin
                errors++;
                $display("FAIL seq_%0d: valid=%b pc_id=%h instr=%h, required 1/%h/%h",
                         i, bus.Valid_ID, bus.PC_ID, bus.Instr_ID, 32'(4 * i), 32'(32'h100 + i));
            end
        end
    endtask

    task automatic test_stall();
        restart(1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'h4 || bus.Instr_ID !== 32'h101 || bus.imem_addr !== 32'hC) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b pc_id=%h instr=%h addr=%h, required 1/4/101/c",
                         i, bus.Valid_ID, bus.PC_ID, bus.Instr_ID, bus.imem_addr);
            end
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'(8 + 4 * i) || bus.Instr_ID !== 32'(32'h102 + i)) begin
                errors++;
                $display("FAIL stall_release_%0d: valid=%b pc_id=%h instr=%h, required 1/%h/%h",
                         i, bus.Valid_ID, bus.PC_ID, bus.Instr_ID, 32'(8 + 4 * i), 32'(32'h102 + i));
            end
        end
    endtask

    task automatic test_branch();
        restart(2);
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h40;
        tick();
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.Valid_ID !== 1'b0 || bus.Instr_ID !== 32'h0) begin
                errors++;
                $display("FAIL branch_bubble_%0d: valid=%b instr=%h, required 0/0", i, bus.Valid_ID, bus.Instr_ID);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'(32'h40 + 4 * i) || bus.Instr_ID !== 32'(32'h110 + i)) begin
                errors++;
                $display("FAIL branch_target_%0d: valid=%b pc_id=%h instr=%h, required 1/%h/%h",
                         i, bus.Valid_ID, bus.PC_ID, bus.Instr_ID, 32'(32'h40 + 4 * i), 32'(32'h110 + i));
            end
            tick();
        end
    endtask

    task automatic test_branch_stall();
        restart(1);
        bus.stall = 1'b1;
        tick();
        tick();
        checks++;
        if (dut.hold_valid !== 1'b1) begin
            errors++;
            $display("FAIL bs_hold_setup: hold_valid=%b, required 1", dut.hold_valid);
        end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h100;
        tick();
        bus.branch_taken = 1'b0;
        bus.stall = 1'b0;
        checks++;
        if (dut.hold_valid !== 1'b0 || bus.Valid_ID !== 1'b0 || bus.Instr_ID !== 32'h0) begin
            errors++;
            $display("FAIL bs_flush: hold_valid=%b valid=%b instr=%h, required 0/0/0",
                     dut.hold_valid, bus.Valid_ID, bus.Instr_ID);
        end
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b0 || bus.Instr_ID !== 32'h0) begin
            errors++;
            $display("FAIL bs_bubble2: valid=%b instr=%h, required 0/0", bus.Valid_ID, bus.Instr_ID);
        end
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'h100 || bus.Instr_ID !== 32'h140) begin
            errors++;
            $display("FAIL bs_target: valid=%b pc_id=%h instr=%h, required 1/100/140",
                     bus.Valid_ID, bus.PC_ID, bus.Instr_ID);
        end
    endtask

    task automatic test_fields();
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h80;
        tick();
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.OpCode !== 5'h0 || bus.InstructionP1 !== 5'h0 || bus.InstructionP2 !== 10'h0) begin
                errors++;
                $display("FAIL fields_bubble_%0d: op=%h p1=%h p2=%h, required 0/0/0",
                         i, bus.OpCode, bus.InstructionP1, bus.InstructionP2);
            end
            tick();
        end
        checks++;
        if (bus.Instr_ID !== 32'hC00003FF || bus.OpCode !== 5'b11000 || bus.InstructionP1 !== 5'h1F ||
            bus.InstructionP2 !== 10'h3FF) begin
            errors++;
            $display("FAIL fields_decode: instr=%h op=%b p1=%h p2=%h, required c00003ff/11000/1f/3ff",
                     bus.Instr_ID, bus.OpCode, bus.InstructionP1, bus.InstructionP2);
        end
    endtask

    task automatic test_wrap();
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.PC_ID !== 32'hFFFF_FFFC || bus.Instr_ID !== 32'h1FF) begin
            errors++;
            $display("FAIL wrap_last: pc_id=%h instr=%h, required fffffffc/1ff", bus.PC_ID, bus.Instr_ID);
        end
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'h0 || bus.Instr_ID !== 32'h100) begin
            errors++;
            $display("FAIL wrap_zero: valid=%b pc_id=%h instr=%h, required 1/0/100",
                     bus.Valid_ID, bus.PC_ID, bus.Instr_ID);
        end
    endtask

    task automatic test_reset_mid();
        restart(1);
        bus.stall = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b0 || bus.PC_ID !== 32'h0 || bus.Instr_ID !== 32'h0 || dut.hold_valid !== 1'b0 ||
            bus.OpCode !== 5'h0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%b pc_id=%h instr=%h hold_valid=%b, required 0/0/0/0",
                     bus.Valid_ID, bus.PC_ID, bus.Instr_ID, dut.hold_valid);
        end
        rst = 1'b0;
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bubble: valid=%b, required 0", bus.Valid_ID);
        end
        tick();
        checks++;
        if (bus.Valid_ID !== 1'b1 || bus.PC_ID !== 32'h0 || bus.Instr_ID !== 32'h100) begin
            errors++;
            $display("FAIL midreset_restart: valid=%b pc_id=%h instr=%h, required 1/0/100",
                     bus.Valid_ID, bus.PC_ID, bus.Instr_ID);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 32'(32'h100 + i);
        rom[8'h20] = 32'hC00003FF;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;

        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_fields();
        test_wrap();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the SIMD AES core.
- Drives the synchronous instruction memory, registers the fetched word with its PC, and slices the OpCode/InstructionP1/InstructionP2 fields consumed directly by the decode-stage immediate generator.
- Supports a pipeline stall from hazard logic and a branch redirect/flush from the execute stage.

Parameters:
- PC_WIDTH, 32, PC and address width.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, increment per sequential instruction (byte-addressed 32-bit words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  freeze PC and IF/ID contents.
- branch_taken  in  1  redirect fetch and flush the stage.
- branch_target  in  PC_WIDTH  redirect address.
- imem_addr  out  PC_WIDTH  instruction memory read address.
- imem_rdata  in  32  read data, valid one cycle after imem_addr.
- PC_ID  out  PC_WIDTH  PC of the registered instruction.
- Instr_ID  out  [0:31]  registered instruction word.
- Valid_ID  out  1  Instr_ID holds a real instruction.
- OpCode  out  [0:4]  Instr_ID[0:4], combinational.
- InstructionP1  out  [0:4]  Instr_ID[27:31], combinational.
- InstructionP2  out  [0:9]  Instr_ID[22:31], combinational.

Behaviour:
- Clocking: single clk domain; rst is synchronous and active-high.
- Internal registers: PC, fetch_addr (address issued last cycle), fetch_pending (imem_rdata this cycle is wanted), hold_instr and hold_valid (one-entry skid buffer).
- Reset: PC=RESET_PC; fetch_pending=0; hold_valid=0; PC_ID=0; Instr_ID=0; Valid_ID=0.
- Reset mid-operation discards everything, including the hold buffer.
- imem_addr = PC, combinational.
- Priority at each edge (rst is outside this chain and overrides it): branch_taken > stall > normal.
- Normal (no stall, no branch):
  - PC <= PC+PC_STEP, modulo 2^PC_WIDTH (wraps silently).
  - fetch_addr <= PC; fetch_pending <= 1.
  - Valid_ID <= fetch_pending; PC_ID <= fetch_addr.
  - Instr_ID <= hold_valid ? hold_instr : imem_rdata; hold_valid <= 0.
  - When Valid_ID would be 0, Instr_ID <= 0 (bubble = all-zero NOP).
- Stall (no branch):
  - PC, fetch_addr, PC_ID, Instr_ID and Valid_ID hold.
  - If fetch_pending=1 and hold_valid=0: hold_instr <= imem_rdata, hold_valid <= 1.
  - fetch_pending <= 0 once captured, so the in-flight word is neither lost nor duplicated.
  - Stalls of any length are allowed.
- Release after stall: the first ID load takes hold_instr with PC_ID=fetch_addr; sequential fetch then continues.
- Branch (regardless of stall):
  - PC <= branch_target; fetch_pending <= 0; hold_valid <= 0.
  - Valid_ID <= 0; Instr_ID <= 0.
  - Exactly two bubble cycles, then branch_target appears in ID.
- Latency: word at address A appears in ID two edges after A is driven on imem_addr, absent stalls.
- After rst deasserts: Valid_ID=0 for the first edge; the second edge loads RESET_PC.
- Field outputs follow Instr_ID combinationally and are all-zero during bubbles.

Test Plan:
- Reset release, ROM[n]=n+0x100, no stall:
  - Valid_ID=0 after the first edge.
  - Then PC_ID=0,4,8,12 with Instr_ID=0x100,0x101,0x102,0x103 on consecutive edges.
- Stall high for 3 cycles while PC_ID=4:
  - PC_ID=4 and Instr_ID=0x101 hold for 3 cycles, imem_addr frozen.
  - After release: PC_ID=8 then 12, no skip or duplicate.
- branch_taken=1, branch_target=0x40 while PC_ID=8:
  - Two cycles with Valid_ID=0 and Instr_ID=0.
  - Then PC_ID=0x40, Instr_ID=ROM[0x10], then 0x44.
- branch_taken=1 with stall=1 in the same cycle, hold_valid=1:
  - Branch wins, hold buffer discarded, two bubbles, then PC_ID=branch_target.
- ROM word 0xC00003FF fetched:
  - OpCode=5'b11000, InstructionP2=10'h3FF, InstructionP1=5'h1F.
  - During bubbles all three fields are 0.
- rst asserted during a 2-cycle stall with hold_valid=1:
  - Next edge all outputs 0 and hold_valid=0.
  - Fetch restarts at RESET_PC with the reset latency.
